// File: rtl/test_sequencer.sv
// test_sequencer
//   Harness-side controller for one self-checking DUT. Holds the DUT in
//   reset for RESET_CYCLES cycles, then runs it while watching its done and
//   error strobes, and reaches a sticky pass or fail verdict. A cycle
//   watchdog turns a hung DUT into a timeout failure.
//
//   Optional feature macro: TEST_SEQUENCER_REPORT_EN
//     When defined, the verdict is also reported with simulation system
//     tasks ($write/$finish on pass, $display/$stop on fail) and the
//     pass/fail exclusivity is asserted. When undefined, the block is
//     plain synthesizable logic and verdicts appear only on the ports.
//
//   Parameters
//     RESET_CYCLES   >= 1      cycles dut_reset_l stays low after reset falls
//     TIMEOUT_CYCLES 1..2^32-1 RUN cycles before a timeout failure
//     DONE_COUNT     1..255    dut_done pulses required for a pass
//
//   Ports
//     clk          in   clock
//     reset        in   synchronous active-high reset of this block
//     dut_reset_l  out  registered active-low reset to the DUT
//     dut_done     in   DUT completion strobe, one pulse per event
//     dut_error    in   DUT error strobe
//     run_active   out  high while running the DUT
//     pass         out  sticky pass verdict
//     fail         out  sticky fail verdict
//     status       out  00 hold/run, 01 pass, 10 fail-error, 11 fail-timeout
//     cycle_count  out  cycles spent running, frozen at the verdict
//     done_seen    out  done pulses accepted while running
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   HOLD  | DUT held in reset, counting out the reset window
//   RUN   | DUT released, watching strobes and the watchdog
//   PASS  | required done pulses seen, terminal until reset
//   FAIL  | error strobe or watchdog expiry, terminal until reset

module test_sequencer #(
    parameter int unsigned RESET_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100,
    parameter int unsigned DONE_COUNT     = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        dut_reset_l,
    input  logic        dut_done,
    input  logic        dut_error,
    output logic        run_active,
    output logic        pass,
    output logic        fail,
    output logic [1:0]  status,
    output logic [31:0] cycle_count,
    output logic [7:0]  done_seen
);

    localparam logic [31:0] HOLD_LAST    = 32'(RESET_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  DONE_TARGET  = 8'(DONE_COUNT);

    localparam logic [1:0] STAT_IDLE    = 2'b00;
    localparam logic [1:0] STAT_PASS    = 2'b01;
    localparam logic [1:0] STAT_ERROR   = 2'b10;
    localparam logic [1:0] STAT_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] hold_cnt_q;
    logic [31:0] hold_cnt_d;

    logic        dut_reset_l_d;
    logic        run_active_d;
    logic        pass_d;
    logic        fail_d;
    logic [1:0]  status_d;
    logic [31:0] cycle_count_d;
    logic [7:0]  done_seen_d;
    logic [7:0]  done_seen_inc;

    assign done_seen_inc = done_seen + 8'd1;

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        dut_reset_l_d = dut_reset_l;
        run_active_d  = run_active;
        pass_d        = pass;
        fail_d        = fail;
        status_d      = status;
        cycle_count_d = cycle_count;
        done_seen_d   = done_seen;

        case (state_q)
            ST_HOLD: begin
                dut_reset_l_d = 1'b0;
                run_active_d  = 1'b0;
                hold_cnt_d    = hold_cnt_q + 32'd1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d       = ST_RUN;
                    dut_reset_l_d = 1'b1;
                    run_active_d  = 1'b1;
                    cycle_count_d = 32'd0;
                    done_seen_d   = 8'd0;
                end
            end

            ST_RUN: begin
                // The count advances on the exit edge too, so a timeout
                // leaves cycle_count equal to TIMEOUT_CYCLES.
                cycle_count_d = cycle_count + 32'd1;
                if (dut_done) begin
                    done_seen_d = done_seen_inc;
                end

                // Error beats a pass on the same edge; a pass beats the
                // watchdog on the same edge.
                if (dut_error) begin
                    state_d      = ST_FAIL;
                    run_active_d = 1'b0;
                    fail_d       = 1'b1;
                    status_d     = STAT_ERROR;
                end else if (dut_done && (done_seen_inc == DONE_TARGET)) begin
                    state_d      = ST_PASS;
                    run_active_d = 1'b0;
                    pass_d       = 1'b1;
                    status_d     = STAT_PASS;
                end else if (cycle_count == TIMEOUT_LAST) begin
                    state_d      = ST_FAIL;
                    run_active_d = 1'b0;
                    fail_d       = 1'b1;
                    status_d     = STAT_TIMEOUT;
                end
            end

            // Terminal: the DUT stays out of reset so its final state can
            // be inspected; counters hold their entry values.
            ST_PASS, ST_FAIL: begin
                run_active_d = 1'b0;
            end

            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= 32'd0;
            dut_reset_l <= 1'b0;
            run_active  <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            status      <= STAT_IDLE;
            cycle_count <= 32'd0;
            done_seen   <= 8'd0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            dut_reset_l <= dut_reset_l_d;
            run_active  <= run_active_d;
            pass        <= pass_d;
            fail        <= fail_d;
            status      <= status_d;
            cycle_count <= cycle_count_d;
            done_seen   <= done_seen_d;
        end
    end

`ifdef TEST_SEQUENCER_REPORT_EN
    always_ff @(posedge clk) begin
        if (!reset && (state_q == ST_RUN) && (state_d == ST_PASS)) begin
            $write("*-* All Finished *-*\n");
            $finish;
        end
        if (!reset && (state_q == ST_RUN) && (state_d == ST_FAIL)) begin
            $display("%%Error: test_sequencer status=%b cycle_count=%0d",
                     status_d, cycle_count_d);
            $stop;
        end
    end

    pass_fail_exclusive: assert property (@(posedge clk) !(pass && fail));
`else
    // Verdicts are reported only through the ports in this build.
`endif

endmodule
